// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared constants and types for the Cardinal ring output-link
// arbiter.
//   CARDINAL_DW / CARDINAL_NREQ : default packet width and requester count
//   vc_e                        : virtual channel / link phase (VC_EVEN, VC_ODD)
//   REQ_CW/REQ_CCW/REQ_PE       : requester indices
//   rr_next()                   : round-robin successor of an index modulo n
package cardinal_pkg;

  localparam int unsigned CARDINAL_DW   = 64;
  localparam int unsigned CARDINAL_NREQ = 3;
  localparam int unsigned NUM_VC        = 2;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

  localparam int unsigned REQ_CW  = 0;
  localparam int unsigned REQ_CCW = 1;
  localparam int unsigned REQ_PE  = 2;

  localparam logic [15:0] GNT_CNT_MAX = 16'hFFFF;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cardinal_rr_pick.sv
// cardinal_rr_pick: combinational NREQ-wide round-robin picker.
//   elig : eligible requester mask
//   ptr  : highest-priority index (0..NREQ-1)
//   gnt  : one-hot winner, first eligible index from ptr upward, wrapping
//   vld  : at least one requester was eligible
module cardinal_rr_pick
  import cardinal_pkg::*;
#(
  parameter int unsigned NREQ = CARDINAL_NREQ,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            vld
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sum = '0;
    idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      // ptr < NREQ, so one conditional subtract is a complete modulo
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!vld && elig[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cardinal_link_arb.sv
// cardinal_link_arb: round-robin arbiter sharing one outgoing ring link among
// NREQ requesters (cw, ccw, PE/NIC) over two virtual channels, each with a
// one-entry output slot. The link phase (polarity) toggles every cycle; the
// slot of the VC matching the phase drains when the downstream is ready.
//   clk, reset          : clock, asynchronous active-high reset
//   req/req_vc/req_data : per-requester packet, its VC and payload
//   gnt                 : combinational one-hot grant (transfer at req&gnt)
//   polarity            : current link phase (0 = even VC owns link)
//   so/data_out         : registered send-out valid and packet
//   ro                  : downstream ready for the VC selected by polarity
//   gnt_cnt             : saturating per-requester grant counters, present
//                         only when CARDINAL_ARB_STATS_EN is defined
module cardinal_link_arb
  import cardinal_pkg::*;
#(
  parameter int unsigned NREQ = CARDINAL_NREQ,
  parameter int unsigned DW   = CARDINAL_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_vc,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               polarity,
  output logic               so,
  input  logic               ro,
  output logic [DW-1:0]      data_out
`ifdef CARDINAL_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] gnt_cnt
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  vc_e                          polarity_q, polarity_d;
  logic [NUM_VC-1:0]            buf_full_q, buf_full_d;
  logic [NUM_VC-1:0][DW-1:0]    buf_data_q, buf_data_d;
  logic [NUM_VC-1:0][PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic                         so_q, so_d;
  logic [DW-1:0]                data_out_q, data_out_d;

  logic [NUM_VC-1:0][NREQ-1:0]  elig;
  logic [NUM_VC-1:0][NREQ-1:0]  win;
  logic [NUM_VC-1:0]            win_vld;
  logic [NUM_VC-1:0]            drain_vc;

  // Eligibility is gated by reset so gnt reads 0 while reset is held even
  // though the cleared slots would otherwise accept requests.
  always_comb begin
    elig = '0;
    if (!reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          elig[v][i] = req[i] & (req_vc[i] == v[0]) & ~buf_full_q[v];
        end
      end
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    cardinal_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
    ) u_pick (
      .elig (elig[v]),
      .ptr  (rr_ptr_q[v]),
      .gnt  (win[v]),
      .vld  (win_vld[v])
    );
  end

  always_comb begin
    gnt = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      gnt = gnt | win[v];
    end
  end

  always_comb begin
    polarity_d  = (polarity_q == VC_EVEN) ? VC_ODD : VC_EVEN;
    drain_vc[0] = buf_full_q[0] & ro & (polarity_q == VC_EVEN);
    drain_vc[1] = buf_full_q[1] & ro & (polarity_q == VC_ODD);
    so_d        = |drain_vc;
    data_out_d  = data_out_q;
    if (drain_vc[0]) begin
      data_out_d = buf_data_q[0];
    end else if (drain_vc[1]) begin
      data_out_d = buf_data_q[1];
    end

    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    rr_ptr_d   = rr_ptr_q;
    // A draining slot was full at cycle start, so it cannot also win here;
    // refill of that VC happens no earlier than the following cycle.
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (drain_vc[v]) begin
        buf_full_d[v] = 1'b0;
      end
      if (win_vld[v]) begin
        buf_full_d[v] = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (win[v][i]) begin
            buf_data_d[v] = req_data[i*DW +: DW];
            rr_ptr_d[v]   = PW'(rr_next(i, NREQ));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity_q <= VC_EVEN;
      buf_full_q <= '0;
      buf_data_q <= '0;
      rr_ptr_q   <= '0;
      so_q       <= 1'b0;
      data_out_q <= '0;
    end else begin
      polarity_q <= polarity_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      rr_ptr_q   <= rr_ptr_d;
      so_q       <= so_d;
      data_out_q <= data_out_d;
    end
  end

  assign polarity = polarity_q;
  assign so       = so_q;
  assign data_out = data_out_q;

`ifdef CARDINAL_ARB_STATS_EN
  logic [NREQ-1:0][15:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i] && (gnt_cnt_q[i] != GNT_CNT_MAX)) begin
        gnt_cnt_d[i] = gnt_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_cardinal_link_arb.sv
// tb_cardinal_link_arb: self-checking bench for cardinal_link_arb. Inputs are
// driven 1 time unit after the rising edge and outputs are checked 2 units
// later, well before the next edge.
module tb_cardinal_link_arb;
  import cardinal_pkg::*;

  localparam int unsigned NREQ = CARDINAL_NREQ;
  localparam int unsigned DW   = CARDINAL_DW;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_vc;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               polarity;
  logic               so;
  logic               ro;
  logic [DW-1:0]      data_out;
`ifdef CARDINAL_ARB_STATS_EN
  logic [NREQ*16-1:0] gnt_cnt;
`endif

  cardinal_link_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_vc   (req_vc),
    .req_data (req_data),
    .gnt      (gnt),
    .polarity (polarity),
    .so       (so),
    .ro       (ro),
    .data_out (data_out)
`ifdef CARDINAL_ARB_STATS_EN
    ,
    .gnt_cnt  (gnt_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit into cycle 0 of a fresh run (polarity 0).
  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    req_vc   = '0;
    req_data = '0;
    ro       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   req;
    logic [2:0]   vc;
    logic [191:0] data;
    logic         ro;
    logic [2:0]   gnt;
    logic         so;
    logic [63:0]  dout;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] v, input logic [191:0] d,
                              input logic o, input logic [2:0] g, input logic s, input logic [63:0] q);
    vec_t t;
    t.req = r; t.vc = v; t.data = d; t.ro = o; t.gnt = g; t.so = s; t.dout = q;
    return t;
  endfunction

  // Table: round-robin fairness on VC0 (rows 0..13), then VC independence.
  task automatic run_table();
    vec_t tbl[20];
    logic [63:0]  d0, d1, d2, da, db;
    logic [191:0] df, dab;
    d0 = 64'h10; d1 = 64'h11; d2 = 64'h12; da = 64'hA; db = 64'hB;
    df  = {d2, d1, d0};
    dab = {64'h0, db, da};
    tbl[0]  = mk(3'b111, 3'b000, df,  1'b1, 3'b001, 1'b0, 64'h0);
    tbl[1]  = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, 64'h0);
    tbl[2]  = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, 64'h0);
    tbl[3]  = mk(3'b111, 3'b000, df,  1'b1, 3'b010, 1'b1, d0);
    tbl[4]  = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, d0);
    tbl[5]  = mk(3'b111, 3'b000, df,  1'b1, 3'b100, 1'b1, d1);
    tbl[6]  = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, d1);
    tbl[7]  = mk(3'b111, 3'b000, df,  1'b1, 3'b001, 1'b1, d2);
    tbl[8]  = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, d2);
    tbl[9]  = mk(3'b111, 3'b000, df,  1'b1, 3'b010, 1'b1, d0);
    tbl[10] = mk(3'b111, 3'b000, df,  1'b1, 3'b000, 1'b0, d0);
    tbl[11] = mk(3'b111, 3'b000, df,  1'b1, 3'b100, 1'b1, d1);
    tbl[12] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b0, d1);
    tbl[13] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b1, d2);
    tbl[14] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b0, d2);
    tbl[15] = mk(3'b011, 3'b010, dab, 1'b1, 3'b011, 1'b0, d2);
    tbl[16] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b0, d2);
    tbl[17] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b1, da);
    tbl[18] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b1, db);
    tbl[19] = mk(3'b000, 3'b000, '0,  1'b1, 3'b000, 1'b0, db);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      req = tbl[k].req; req_vc = tbl[k].vc; req_data = tbl[k].data; ro = tbl[k].ro;
      #2;
      chk($sformatf("tbl%0d_gnt", k),  64'(gnt),      64'(tbl[k].gnt));
      chk($sformatf("tbl%0d_so", k),   64'(so),       64'(tbl[k].so));
      chk($sformatf("tbl%0d_dout", k), data_out,      tbl[k].dout);
      chk($sformatf("tbl%0d_pol", k),  64'(polarity), 64'(k % 2));
`ifdef CARDINAL_ARB_STATS_EN
      if (k == 12) chk("fair_gnt_cnt", 64'(gnt_cnt), 64'({16'd2, 16'd2, 16'd2}));
`endif
      tick();
    end
  endtask

  // Backpressure, no same-cycle refill, then reset with both slots full.
  task automatic run_sequences();
    do_reset();
    // c0: req0 puts 0xC into the VC1 slot; downstream stalled
    req = 3'b001; req_vc = 3'b001; req_data = {128'h0, 64'hC}; ro = 1'b0;
    #2; chk("bp_c0_gnt", 64'(gnt), 64'h1);
    tick();
    req = 3'b100; req_vc = 3'b100; req_data = {64'hE, 128'h0};
    for (int c = 1; c <= 6; c++) begin
      #2;
      chk($sformatf("bp_c%0d_gnt", c), 64'(gnt), 64'h0);
      chk($sformatf("bp_c%0d_so", c),  64'(so),  64'h0);
      tick();
    end
    ro = 1'b1;                                   // c7: odd phase, drains 0xC
    #2; chk("bp_c7_gnt", 64'(gnt), 64'h0); chk("bp_c7_pol", 64'(polarity), 64'h1);
    tick();
    #2; chk("bp_c8_gnt", 64'(gnt), 64'h4); chk("bp_c8_so", 64'(so), 64'h1);
    chk("bp_c8_dout", data_out, 64'hC);
    tick();
    req = 3'b000;
    #2; chk("bp_c9_so", 64'(so), 64'h0);
    tick();
    // c10..13: VC0 slot filled with 0xF, drained in c12 while req0 waits
    req = 3'b010; req_vc = 3'b000; req_data = {64'h0, 64'hF, 64'h0};
    #2; chk("rf_c10_gnt", 64'(gnt), 64'h2); chk("rf_c10_dout", data_out, 64'hE);
    tick();
    req = 3'b001; req_vc = 3'b000; req_data = {128'h0, 64'h6};
    #2; chk("rf_c11_gnt", 64'(gnt), 64'h0);
    tick();
    #2; chk("rf_c12_gnt", 64'(gnt), 64'h0);
    tick();
    #2; chk("rf_c13_gnt", 64'(gnt), 64'h1); chk("rf_c13_dout", data_out, 64'hF);
    tick();
    // c14..16: fill both slots with downstream stalled, then reset
    req = 3'b010; req_vc = 3'b010; req_data = {64'h0, 64'h1, 64'h0};
    #2; chk("rs_c14_gnt", 64'(gnt), 64'h2);
    tick();
    ro = 1'b0; req = 3'b100; req_vc = 3'b000; req_data = {64'h8, 128'h0};
    #2; chk("rs_c15_gnt", 64'(gnt), 64'h4); chk("rs_c15_dout", data_out, 64'h6);
    tick();
    req = 3'b011; req_vc = 3'b010; req_data = {64'h0, 64'h3, 64'h2};
    #2; chk("rs_c16_gnt_full", 64'(gnt), 64'h0); chk("rs_c16_dout", data_out, 64'h6);
    reset = 1'b1;
    #1;
    chk("rs_async_so", 64'(so), 64'h0);
    chk("rs_async_dout", data_out, 64'h0);
    chk("rs_async_gnt", 64'(gnt), 64'h0);
    @(posedge clk); #1;
    chk("rs_held_gnt", 64'(gnt), 64'h0);
    chk("rs_held_pol", 64'(polarity), 64'h0);
    reset = 1'b0; req = '0; ro = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("rs_post%0d_pol", c), 64'(polarity), 64'(c % 2));
      chk($sformatf("rs_post%0d_so", c),  64'(so),       64'h0);
      tick();
    end
  endtask

`ifdef CARDINAL_ARB_STATS_EN
  // req0 alternates VC against the phase so it wins once per cycle.
  task automatic run_saturation();
    do_reset();
    ro = 1'b1; req = 3'b001; req_data = {128'h0, 64'h5};
    for (int n = 0; n < 65537; n++) begin
      req_vc = {2'b00, ~n[0]};
      if (n == 1000) begin
        #2; chk("sat_cnt_1000", 64'(gnt_cnt[15:0]), 64'd1000);
      end
      tick();
    end
    req = '0;
    #2;
    chk("sat_cnt0", 64'(gnt_cnt[15:0]), 64'hFFFF);
    chk("sat_cnt12", 64'(gnt_cnt[47:16]), 64'h0);
    tick();
  endtask
`endif

  task automatic run_random(input int unsigned ncyc);
    bit          pend[3];
    bit          pvc[3];
    logic [63:0] pdata[3];
    bit          m_full[2];
    logic [63:0] m_data[2];
    int          m_ptr[2];
    int          m_pol;
    bit          m_so;
    logic [63:0] m_dout;
    int          m_cnt[3];
    int          wv[2];
    int          idx;
    logic [2:0]  eg;
    do_reset();
    for (int i = 0; i < 3; i++) begin pend[i] = 0; m_cnt[i] = 0; end
    for (int v = 0; v < 2; v++) begin m_full[v] = 0; m_ptr[v] = 0; m_data[v] = '0; end
    m_pol = 0; m_so = 0; m_dout = '0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(99, 0) < 60) begin
          pend[i]  = 1;
          pvc[i]   = ($urandom_range(1, 0) == 1);
          pdata[i] = {$urandom, $urandom};
        end
        req[i] = pend[i];
        req_vc[i] = pvc[i];
        req_data[i*64 +: 64] = pdata[i];
      end
      ro = ($urandom_range(99, 0) < 70);
      #2;
      eg = '0;
      for (int v = 0; v < 2; v++) begin
        wv[v] = -1;
        if (!m_full[v]) begin
          for (int k = 0; k < 3; k++) begin
            idx = (m_ptr[v] + k) % 3;
            if (wv[v] < 0 && pend[idx] && (int'(pvc[idx]) == v)) wv[v] = idx;
          end
        end
        if (wv[v] >= 0) eg[wv[v]] = 1'b1;
      end
      chk($sformatf("rnd%0d_gnt", c),  64'(gnt),      64'(eg));
      chk($sformatf("rnd%0d_so", c),   64'(so),       64'(m_so));
      chk($sformatf("rnd%0d_dout", c), data_out,      m_dout);
      chk($sformatf("rnd%0d_pol", c),  64'(polarity), 64'(m_pol));
`ifdef CARDINAL_ARB_STATS_EN
      for (int i = 0; i < 3; i++)
        chk($sformatf("rnd%0d_cnt%0d", c, i), 64'(gnt_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
      if (m_full[m_pol] && ro) begin
        m_so = 1; m_dout = m_data[m_pol]; m_full[m_pol] = 0;
      end else begin
        m_so = 0;
      end
      for (int v = 0; v < 2; v++) begin
        if (wv[v] >= 0) begin
          m_full[v] = 1;
          m_data[v] = pdata[wv[v]];
          m_ptr[v]  = (wv[v] + 1) % 3;
          pend[wv[v]] = 0;
          if (m_cnt[wv[v]] < 65535) m_cnt[wv[v]]++;
        end
      end
      m_pol = 1 - m_pol;
      tick();
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_vc = '0; req_data = '0; ro = 1'b0;
    run_table();
    run_sequences();
    run_random(600);
`ifdef CARDINAL_ARB_STATS_EN
    run_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
